// File: rtl/z80_bus_pkg.sv
// z80_bus_pkg: shared types and defaults for the Z80 external-bus arbiter.
//   state_t       - arbiter FSM states (IDLE, REQ, GRANT, RELEASE)
//   NREQ_DEF      - default number of on-chip bus requesters
//   HOLD_MAX_DEF  - default maximum grant length (only used when
//                   BUSARB_TIMEOUT_EN is defined)
//   IDXW_DEF      - owner index width for the default requester count
package z80_bus_pkg;

  localparam int NREQ_DEF     = 4;
  localparam int HOLD_MAX_DEF = 255;
  localparam int IDXW_DEF     = $clog2(NREQ_DEF);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/z80_bus_arbiter_if.sv
// z80_bus_arbiter_if: requester/CPU-handshake bundle of the bus arbiter.
//   req         - level request per requester
//   gnt         - one-hot grant
//   nBUSRQ      - bus request to the CPU core, active low
//   nBUSACK     - bus acknowledge from the CPU core, active low
//   owner_valid - high while any gnt bit is high
//   owner_idx   - index of the current or last owner
//   timeout     - one-cycle pulse on a forced revoke
// Modports: master is the arbiter side, slave is the requesters + CPU side.
// Handshake: a requester holds req high for as long as it wants the bus and
// may drive the bus only while its gnt bit is high; the arbiter holds
// nBUSRQ low until the owner drops req, and a grant is only issued after
// the CPU answers nBUSRQ=0 with nBUSACK=0.
interface z80_bus_arbiter_if #(
  parameter int NREQ = z80_bus_pkg::NREQ_DEF,
  parameter int IDXW = $clog2(NREQ)
);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            nBUSRQ;
  logic            nBUSACK;
  logic            owner_valid;
  logic [IDXW-1:0] owner_idx;
  logic            timeout;

  modport master (
    input  req, nBUSACK,
    output gnt, nBUSRQ, owner_valid, owner_idx, timeout
  );

  modport slave (
    output req, nBUSACK,
    input  gnt, nBUSRQ, owner_valid, owner_idx, timeout
  );

endinterface

// File: rtl/z80_rr_pick.sv
// z80_rr_pick: combinational round-robin picker.
//   req_vec - eligible request vector
//   ptr     - index with the highest priority this round
//   onehot  - one-hot winner (0 when nothing requests)
//   idx     - winner index (0 when nothing requests)
//   any     - high when at least one request is present
// Search runs upward from ptr and wraps NREQ-1 -> 0.
module z80_rr_pick
  import z80_bus_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_vec,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  always_comb begin : pick
    int j;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req_vec[j]) begin
        any       = 1'b1;
        idx       = IDXW'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/z80_bus_arbiter.sv
// z80_bus_arbiter: shares the Z80 external bus between the CPU core and
// NREQ on-chip masters. Requests the bus from the core with nBUSRQ, waits
// for nBUSACK, then grants one requester in round-robin order. The bus
// always goes back to the CPU between two owners.
// Ports:
//   CLK       - core clock, rising edge
//   RESET     - asynchronous active-high reset
//   bus       - z80_bus_arbiter_if.master (req/gnt/nBUSRQ/nBUSACK/owner/timeout)
//   state_dbg - current FSM state
// Optional feature: define BUSARB_TIMEOUT_EN to bound each grant to
// HOLD_MAX cycles; an overlong owner is revoked, timeout pulses, and that
// requester is masked until it drops its request. Without the macro the
// grant is unbounded, the mask is constant 0 and timeout is tied 0.
module z80_bus_arbiter
  import z80_bus_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  parameter int IDXW     = $clog2(NREQ)
) (
  input  logic   CLK,
  input  logic   RESET,
  z80_bus_arbiter_if.master bus,
  output state_t state_dbg
);

  state_t          state_q, state_n;
  logic [NREQ-1:0] gnt_q, gnt_n;
  logic            nbusrq_q, nbusrq_n;
  logic            owner_valid_q, owner_valid_n;
  logic [IDXW-1:0] owner_idx_q, owner_idx_n;
  logic [IDXW-1:0] ptr_q, ptr_n;
  logic [IDXW-1:0] ptr_after_owner;
  logic [NREQ-1:0] mask_q;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] pick_onehot;
  logic [IDXW-1:0] pick_idx;
  logic            pick_any;
  logic            owner_req;

`ifdef BUSARB_TIMEOUT_EN
  localparam int CNTW = (HOLD_MAX > 256) ? 16 : 8;
  logic [NREQ-1:0] mask_n;
  logic [CNTW-1:0] cnt_q, cnt_n;
  logic            timeout_q, timeout_n;
`else
  assign mask_q = '0;
`endif

  assign elig      = bus.req & ~mask_q;
  assign owner_req = bus.req[owner_idx_q];
  assign ptr_after_owner = (owner_idx_q == IDXW'(NREQ - 1)) ? '0
                                                            : owner_idx_q + 1'b1;

  z80_rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .req_vec (elig),
    .ptr     (ptr_q),
    .onehot  (pick_onehot),
    .idx     (pick_idx),
    .any     (pick_any)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      nbusrq_q      <= 1'b1;
      owner_valid_q <= 1'b0;
      owner_idx_q   <= '0;
      ptr_q         <= '0;
`ifdef BUSARB_TIMEOUT_EN
      mask_q        <= '0;
      cnt_q         <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_n;
      gnt_q         <= gnt_n;
      nbusrq_q      <= nbusrq_n;
      owner_valid_q <= owner_valid_n;
      owner_idx_q   <= owner_idx_n;
      ptr_q         <= ptr_n;
`ifdef BUSARB_TIMEOUT_EN
      mask_q        <= mask_n;
      cnt_q         <= cnt_n;
      timeout_q     <= timeout_n;
`endif
    end
  end

  always_comb begin
    state_n       = state_q;
    gnt_n         = gnt_q;
    nbusrq_n      = nbusrq_q;
    owner_valid_n = owner_valid_q;
    owner_idx_n   = owner_idx_q;
    ptr_n         = ptr_q;
`ifdef BUSARB_TIMEOUT_EN
    // A masked requester becomes eligible again once it is seen idle.
    mask_n        = mask_q & bus.req;
    cnt_n         = cnt_q;
    timeout_n     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|elig) begin
          state_n  = REQ;
          nbusrq_n = 1'b0;
        end
      end
      REQ: begin
        // Winner is chosen at acknowledge time so late requesters compete.
        if (!bus.nBUSACK && pick_any) begin
          state_n       = GRANT;
          gnt_n         = pick_onehot;
          owner_idx_n   = pick_idx;
          owner_valid_n = 1'b1;
`ifdef BUSARB_TIMEOUT_EN
          cnt_n         = '0;
`endif
        end else if (!pick_any) begin
          state_n  = RELEASE;
          nbusrq_n = 1'b1;
        end
      end
      GRANT: begin
        if (bus.nBUSACK) begin
          // CPU took the bus back without being asked: drop the grant.
          state_n       = RELEASE;
          gnt_n         = '0;
          owner_valid_n = 1'b0;
          nbusrq_n      = 1'b1;
        end else if (!owner_req) begin
          state_n       = RELEASE;
          gnt_n         = '0;
          owner_valid_n = 1'b0;
          nbusrq_n      = 1'b1;
          ptr_n         = ptr_after_owner;
`ifdef BUSARB_TIMEOUT_EN
        end else if (cnt_q == CNTW'(HOLD_MAX - 1)) begin
          state_n             = RELEASE;
          gnt_n               = '0;
          owner_valid_n       = 1'b0;
          nbusrq_n            = 1'b1;
          ptr_n               = ptr_after_owner;
          timeout_n           = 1'b1;
          mask_n[owner_idx_q] = 1'b1;
        end else begin
          cnt_n = cnt_q + 1'b1;
`endif
        end
      end
      RELEASE: begin
        if (bus.nBUSACK) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.gnt         = gnt_q;
  assign bus.nBUSRQ      = nbusrq_q;
  assign bus.owner_valid = owner_valid_q;
  assign bus.owner_idx   = owner_idx_q;
`ifdef BUSARB_TIMEOUT_EN
  assign bus.timeout     = timeout_q;
`else
  assign bus.timeout     = 1'b0;
`endif
  assign state_dbg       = state_q;

endmodule
